branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch/decode-side partner to the pipeline control logic.
- Looks up a PC in a tagged, direct-mapped table of 2-bit saturating counters and returns a taken/not-taken guess.
- Control logic returns the resolved branch outcome from the X stage, and this block trains its table on that outcome.
- Also counts resolved branches and mispredictions for the CSR/perf path.

Parameters:
- PC_WIDTH, 32, width of instruction address.
- LINES, 8, number of table entries; power of two, 2..64.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bp_enable  in  1  when 0, pred_taken is forced 0; training and counting continue.
- pc_guess  in  PC_WIDTH  PC of the instruction in FD.
- is_br_guess  in  1  FD instruction is a conditional branch (opcode 0x63).
- hit  out  1  pc_guess matches a valid entry.
- pred_taken  out  1  predicted direction for the FD branch.
- pc_check  in  PC_WIDTH  PC of the instruction in X.
- is_br_check  in  1  X instruction is a conditional branch.
- br_taken_check  in  1  resolved direction from the control logic.
- pred_taken_check  in  1  direction that was predicted for this X branch (pipelined copy of pred_taken).
- br_count  out  CNT_WIDTH  resolved branches since reset.
- mispred_count  out  CNT_WIDTH  mispredicted branches since reset.

Behaviour:
- Address split:
  - IDX = log2(LINES).
  - index = pc[2 +: IDX].
  - tag = pc[PC_WIDTH-1 : 2+IDX].
  - pc[1:0] are ignored.
- Entry state: valid (1b), tag, ctr (2b).
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Guess path is combinational (0-cycle latency):
  - hit = is_br_guess & valid[index] & (tag[index] == guess tag).
  - pred_taken = bp_enable & hit & ctr[index][1].
  - On a miss, pred_taken = 0 (static not-taken).
- Check path is registered; it updates state at the clock edge when is_br_check = 1.
  - Tag match: ctr moves +1 if br_taken_check, else −1, saturating at 11 and 00. No wrap.
  - Tag miss or invalid: allocate the entry. Set valid = 1, tag = check tag, ctr = 10 if taken, else 01. Any previous occupant is overwritten.
  - When is_br_check = 0: no table change.
- Same-cycle guess and check to the same index: the guess sees the pre-update (old) entry; the new value is visible the next cycle.
- Perf counters:
  - br_count += 1 when is_br_check.
  - mispred_count += 1 when is_br_check & (br_taken_check != pred_taken_check).
  - Both wrap modulo 2^CNT_WIDTH.
- Reset:
  - All valid bits, ctr values and both perf counters go to 0 in one cycle, including mid-operation.
  - While rst = 1, check-path updates are ignored.
  - Outputs during and immediately after reset: hit = 0, pred_taken = 0, br_count = 0, mispred_count = 0.
  - Tag storage need not be reset.
- Non-branch PCs never allocate.
- bp_enable affects only pred_taken, not hit or training.

Decomposition:
- Shared package/header:
  - Branch opcode constant 7'h63.
  - Counter encodings SNT/WNT/WT/ST.
  - Index/tag width computation macros.
- One sub-module, bp_cache: direct-mapped valid/tag/data array.
  - One combinational read port and one synchronous write port.
  - Synchronous reset of the valid bits.
- Counter saturation logic stays in branch_predictor.

Test Plan:
1. Reset, then guess pc 0x100 with is_br_guess = 1 → hit = 0, pred_taken = 0; br_count = 0.
2. Check pc 0x100 with taken = 1 (alloc, ctr = 10), then guess 0x100 next cycle → hit = 1, pred_taken = 1. With bp_enable = 0 → pred_taken = 0, hit = 1.
3. Train 0x100 with T, T, T, then NT → ctr 10→11→11→10, pred stays 1. A second NT → 01, pred = 0. Three more NT saturate at 00.
4. Aliasing, LINES = 8: allocate 0x100 (taken), then check 0x120 (same index, different tag, taken = 0) → guess 0x100 gives hit = 0; guess 0x120 gives hit = 1, pred = 0.
5. Same cycle: check 0x100 (ctr 01→10) and guess 0x100 → pred_taken = 0 that cycle, 1 the next cycle.
6. Issue 5 checks, 2 of them with br_taken_check != pred_taken_check → br_count = 5, mispred_count = 2. Assert rst mid-stream → both counters read 0 and guess 0x100 gives hit = 0 the next cycle.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and width helpers for the branch predictor and its tag/counter table.
package branch_predictor_pkg;

  localparam logic [6:0] BR_OPCODE = 7'h63;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic int unsigned idx_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned pc_width, input int unsigned lines);
    return pc_width - 2 - $clog2(lines);
  endfunction

endpackage

// File: rtl/bp_cache.sv
// Direct-mapped valid/tag/counter table: combinational lookups, one synchronous write port.
module bp_cache
  import branch_predictor_pkg::*;
#(
  parameter int unsigned LINES = 8,
  parameter int unsigned TAG_W = 27,
  localparam int unsigned IDX_W = idx_width(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output ctr_e             rd_ctr,
  input  logic [IDX_W-1:0] chk_idx,
  output logic             chk_valid,
  output logic [TAG_W-1:0] chk_tag,
  output ctr_e             chk_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  ctr_e             wr_ctr
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  ctr_e             ctr_q [LINES];
  ctr_e             ctr_d [LINES];

  // Guess-side and check-side lookups both see the pre-write contents.
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];
  assign chk_valid = valid_q[chk_idx];
  assign chk_tag   = tag_q[chk_idx];
  assign chk_ctr   = ctr_q[chk_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      ctr_d[wr_idx]   = wr_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LINES); i++) ctr_q[i] <= SNT;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tags are qualified by valid, so they are left out of reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged 2-bit saturating-counter branch predictor with resolved/mispredict perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned LINES     = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bp_enable,
  input  logic [PC_WIDTH-1:0]  pc_guess,
  input  logic                 is_br_guess,
  output logic                 hit,
  output logic                 pred_taken,
  input  logic [PC_WIDTH-1:0]  pc_check,
  input  logic                 is_br_check,
  input  logic                 br_taken_check,
  input  logic                 pred_taken_check,
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count
);

  localparam int unsigned IDX_W = idx_width(LINES);
  localparam int unsigned TAG_W = tag_width(PC_WIDTH, LINES);

  logic [IDX_W-1:0] guess_idx, check_idx;
  logic [TAG_W-1:0] guess_tag, check_tag;
  logic             rd_valid, chk_valid;
  logic [TAG_W-1:0] rd_tag, chk_tag;
  ctr_e             rd_ctr, chk_ctr;
  logic             wr_en_c;
  ctr_e             wr_ctr_c;
  logic             unused_pc_lsb_c;

  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] mispred_count_q, mispred_count_d;

  assign guess_idx       = pc_guess[2 +: IDX_W];
  assign guess_tag       = pc_guess[PC_WIDTH-1 -: TAG_W];
  assign check_idx       = pc_check[2 +: IDX_W];
  assign check_tag       = pc_check[PC_WIDTH-1 -: TAG_W];
  assign unused_pc_lsb_c = ^{pc_guess[1:0], pc_check[1:0]};

  bp_cache #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_cache (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (guess_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_ctr    (rd_ctr),
    .chk_idx   (check_idx),
    .chk_valid (chk_valid),
    .chk_tag   (chk_tag),
    .chk_ctr   (chk_ctr),
    .wr_en     (wr_en_c),
    .wr_idx    (check_idx),
    .wr_tag    (check_tag),
    .wr_ctr    (wr_ctr_c)
  );

  // Guess path: zero-latency lookup; misses fall back to static not-taken.
  assign hit        = ~rst & is_br_guess & rd_valid & (rd_tag == guess_tag);
  assign pred_taken = bp_enable & hit & rd_ctr[1];

  // Check path: train on a tag match, otherwise allocate with a weak counter.
  always_comb begin
    wr_en_c  = is_br_check & ~rst;
    wr_ctr_c = br_taken_check ? WT : WNT;
    if (chk_valid && (chk_tag == check_tag)) begin
      if (br_taken_check) wr_ctr_c = (chk_ctr == ST)  ? ST  : ctr_e'(chk_ctr + 2'd1);
      else                wr_ctr_c = (chk_ctr == SNT) ? SNT : ctr_e'(chk_ctr - 2'd1);
    end
  end

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (is_br_check) begin
      br_count_d = br_count_q + CNT_WIDTH'(1);
      if (br_taken_check != pred_taken_check) mispred_count_d = mispred_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor (LINES=8: index = pc[4:2], tag = pc[31:5]).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        bp_enable;
  logic [31:0] pc_guess;
  logic        is_br_guess;
  logic        hit;
  logic        pred_taken;
  logic [31:0] pc_check;
  logic        is_br_check;
  logic        br_taken_check;
  logic        pred_taken_check;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .PC_WIDTH  (32),
    .LINES     (8),
    .CNT_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bp_enable        (bp_enable),
    .pc_guess         (pc_guess),
    .is_br_guess      (is_br_guess),
    .hit              (hit),
    .pred_taken       (pred_taken),
    .pc_check         (pc_check),
    .is_br_check      (is_br_check),
    .br_taken_check   (br_taken_check),
    .pred_taken_check (pred_taken_check),
    .br_count         (br_count),
    .mispred_count    (mispred_count)
  );

  // Inputs for one cycle and the outputs expected just before that cycle's edge.
  typedef struct {
    logic        en;
    logic [31:0] pcg;
    logic        isg;
    logic [31:0] pcc;
    logic        isc;
    logic        tk;
    logic        ptc;
    logic        eh;
    logic        ep;
    int          eb;
    int          em;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %0h required %0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [31:0] pcg, input logic isg,
                       input logic [31:0] pcc, input logic isc, input logic tk, input logic ptc);
    rst = r; bp_enable = en; pc_guess = pcg; is_br_guess = isg;
    pc_check = pcc; is_br_check = isc; br_taken_check = tk; pred_taken_check = ptc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_br_count", 0, br_count, 32'd0);
    chk("reset_mispred", 0, mispred_count, 32'd0);

    //            en  pc_guess     isg   pc_check     isc   tk    ptc   hit   pred  br  mis
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0}); // cold miss
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  0, 0}); // alloc WT
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1, 1});
    vecs.push_back('{1'b0, 32'h100, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1, 1}); // disabled
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  1, 1}); // WT->ST
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  2, 1}); // ST sat
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  3, 1});
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,  4, 1}); // ST->WT
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,  5, 2}); // WT->WNT
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  6, 3}); // WNT->SNT
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  7, 3}); // SNT sat
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  8, 3});
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,  9, 3}); // SNT->WNT
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10, 4});
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10, 4}); // same cycle
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11, 5}); // new value
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h120, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 11, 5}); // alias evict
    vecs.push_back('{1'b1, 32'h100, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12, 6});
    vecs.push_back('{1'b1, 32'h120, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12, 6});
    vecs.push_back('{1'b1, 32'h120, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12, 6}); // not a branch
    vecs.push_back('{1'b1, 32'h120, 1'b1, 32'h140, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12, 6}); // no alloc
    vecs.push_back('{1'b1, 32'h140, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12, 6});
    vecs.push_back('{1'b1, 32'h122, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12, 6}); // pc[1:0] ignored

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, vecs[i].en, vecs[i].pcg, vecs[i].isg, vecs[i].pcc, vecs[i].isc, vecs[i].tk, vecs[i].ptc);
      #2;
      chk("hit", i, 32'(hit), 32'(vecs[i].eh));
      chk("pred_taken", i, 32'(pred_taken), 32'(vecs[i].ep));
      chk("br_count", i, br_count, 32'(vecs[i].eb));
      chk("mispred_count", i, mispred_count, 32'(vecs[i].em));
      tick();
    end

    // Counts over five resolutions after a fresh reset, two of them mispredicted.
    drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h100, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h104, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h108, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h100, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h10c, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b1, 32'h100, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("seq_br_count", 100, br_count, 32'd5);
    chk("seq_mispred", 100, mispred_count, 32'd2);
    chk("seq_hit_before_rst", 100, 32'(hit), 32'd1);
    chk("seq_pred_before_rst", 100, 32'(pred_taken), 32'd1);

    // Mid-stream reset with a check in flight: it must be ignored.
    drive(1'b1, 1'b1, 32'h100, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0);
    tick();
    chk("rst_br_count", 101, br_count, 32'd0);
    chk("rst_mispred", 101, mispred_count, 32'd0);
    chk("rst_hit", 101, 32'(hit), 32'd0);
    chk("rst_pred", 101, 32'(pred_taken), 32'd0);
    drive(1'b0, 1'b1, 32'h100, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("post_rst_hit_100", 102, 32'(hit), 32'd0);
    chk("post_rst_br_count", 102, br_count, 32'd0);
    tick();
    drive(1'b0, 1'b1, 32'h104, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("post_rst_hit_104", 103, 32'(hit), 32'd0);
    chk("post_rst_mispred", 103, mispred_count, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
